pll_reset_seq: RTL



---
 rtl/pllseq_pkg.sv | 20 ++
 rtl/sync2ff.sv | 13 +
 rtl/pll_reset_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/pllseq_pkg.sv
// pllseq_pkg: state encoding and default parameter values for the PLL reset sequencer.
package pllseq_pkg;
    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 4;
    localparam int DEF_CNT_W         = 8;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/sync2ff.sv
// sync2ff: two-flop bit synchronizer with synchronous reset to 0.
module sync2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: drives PLL reset, waits for a stable lock, then releases sys_rst.
// Define PLLSEQ_RETRY_LIMIT_EN to stop in a FAIL state after MAX_RETRIES timeouts.
module pll_reset_seq
    import pllseq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] loss_cnt
);
    localparam int TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    if (RST_CYCLES < 2 || MAX_RETRIES < 1) begin : g_bad_param
        $error("pll_reset_seq: RST_CYCLES must be >= 2 and MAX_RETRIES >= 1");
    end
    state_t        state, nxt;
    logic [TW-1:0] timer;
    logic          locked_s, tmo;
`ifdef PLLSEQ_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    logic [RW-1:0] retry_cnt;
`endif
    sync2ff u_sync (.clk(clkin), .rst(rst), .d(locked), .q(locked_s));
    assign state_dbg = state;
    // lock wins over a timeout landing in the same cycle
    assign tmo = state == ST_WAIT_LOCK && !locked_s && timer == TW'(LOCK_TIMEOUT - 1);
    always_comb begin
        nxt = state;
        case (state)
            ST_PLLRST:    nxt = (timer == TW'(RST_CYCLES - 1)) ? ST_WAIT_LOCK : ST_PLLRST;
            ST_WAIT_LOCK: begin
                if (locked_s) nxt = ST_STABLE;
                else if (tmo) begin
`ifdef PLLSEQ_RETRY_LIMIT_EN
                    nxt = (retry_cnt == RW'(MAX_RETRIES - 1)) ? ST_FAIL : ST_PLLRST;
`else
                    nxt = ST_PLLRST;
`endif
                end
            end
            ST_STABLE:    nxt = !locked_s ? ST_WAIT_LOCK :
                                (timer == TW'(STABLE_CYCLES - 1)) ? ST_RUN : ST_STABLE;
            ST_RUN:       nxt = locked_s ? ST_RUN : ST_PLLRST;
`ifdef PLLSEQ_RETRY_LIMIT_EN
            ST_FAIL:      nxt = ST_FAIL;
`endif
            default:      nxt = ST_PLLRST;
        endcase
    end
    always_ff @(posedge clkin) begin
        if (rst) begin
            state    <= ST_PLLRST;
            timer    <= '0;
            loss_cnt <= '0;
            pll_rst  <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
        end else begin
            state    <= nxt;
            timer    <= (nxt != state) ? '0 : timer + TW'(1);
            if (state == ST_RUN && !locked_s && !(&loss_cnt)) loss_cnt <= loss_cnt + CNT_W'(1);
            pll_rst  <= nxt == ST_PLLRST || nxt == ST_FAIL;
            sys_rst  <= nxt != ST_RUN;
            ready    <= nxt == ST_RUN;
        end
    end
`ifdef PLLSEQ_RETRY_LIMIT_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            retry_cnt <= '0;
            fail      <= 1'b0;
        end else begin
            if (tmo) retry_cnt <= retry_cnt + RW'(1);
            else if (state == ST_STABLE && nxt == ST_RUN) retry_cnt <= '0;
            fail <= nxt == ST_FAIL;
        end
    end
`else
    assign fail = 1'b0;
`endif
endmodule
